// File: rtl/f3_move_ctrl.sv
// Command-side master for f3_ram: clears and scrambles the offset store, then feeds
// player moves through a valid/ready handshake and watches for the all-zero (solved) state.
module f3_move_ctrl #(
    parameter int          SCRAMBLE_MOVES = 32,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int          SETTLE_CYCLES  = 2
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    input  logic        move_horizontal,
    input  logic        move_increase,
    output logic        move_ready,
    output logic [3:0]  ram_write_pos,
    output logic        ram_write_horizontal,
    output logic        ram_write_increase,
    output logic        ram_write,
    output logic        ram_reset,
    input  logic        ram_offset_all_zero,
    output logic [15:0] move_count,
    output logic        busy,
    output logic        solved
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SCRAMBLE,
        SCR_SETTLE,
        PLAY,
        ISSUE,
        SETTLE,
        SOLVED
    } state_t;

    localparam logic [7:0] SCR_N     = 8'(SCRAMBLE_MOVES);
    localparam logic [7:0] WAIT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t      state_reg;
    logic [15:0] lfsr_reg;
    logic [7:0]  scr_cnt_reg;
    logic [7:0]  wait_cnt_reg;

    logic [15:0] lfsr_next;
    logic        settle_done;
    logic        batch_open;

    // Galois right shift, taps 16'hB400
    assign lfsr_next   = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    assign settle_done = (wait_cnt_reg == WAIT_LAST);
    assign batch_open  = (scr_cnt_reg < SCR_N);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg            <= IDLE;
            lfsr_reg             <= SEED;
            scr_cnt_reg          <= 8'd0;
            wait_cnt_reg         <= 8'd0;
            move_ready           <= 1'b0;
            ram_write_pos        <= 4'd0;
            ram_write_horizontal <= 1'b0;
            ram_write_increase   <= 1'b0;
            ram_write            <= 1'b0;
            ram_reset            <= 1'b0;
            move_count           <= 16'd0;
            busy                 <= 1'b0;
            solved               <= 1'b0;
        end else begin
            ram_write <= 1'b0;
            ram_reset <= 1'b0;
            if (start) begin
                // start overrides everything, including a handshake in this same cycle
                state_reg    <= CLEAR;
                ram_reset    <= 1'b1;
                lfsr_reg     <= SEED;
                scr_cnt_reg  <= 8'd0;
                wait_cnt_reg <= 8'd0;
                move_count   <= 16'd0;
                move_ready   <= 1'b0;
                busy         <= 1'b1;
                solved       <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg <= IDLE;
                    end
                    CLEAR: begin
                        ram_write            <= 1'b1;
                        ram_write_pos        <= lfsr_reg[3:0];
                        ram_write_horizontal <= lfsr_reg[4];
                        ram_write_increase   <= lfsr_reg[5];
                        lfsr_reg             <= lfsr_next;
                        scr_cnt_reg          <= scr_cnt_reg + 8'd1;
                        state_reg            <= SCRAMBLE;
                    end
                    SCRAMBLE: begin
                        wait_cnt_reg <= 8'd0;
                        state_reg    <= SCR_SETTLE;
                    end
                    SCR_SETTLE: begin
                        if (!settle_done) begin
                            wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        end else if (batch_open || ram_offset_all_zero) begin
                            // a batch that cancelled out restarts the count; the LFSR keeps running
                            ram_write            <= 1'b1;
                            ram_write_pos        <= lfsr_reg[3:0];
                            ram_write_horizontal <= lfsr_reg[4];
                            ram_write_increase   <= lfsr_reg[5];
                            lfsr_reg             <= lfsr_next;
                            scr_cnt_reg          <= batch_open ? scr_cnt_reg + 8'd1 : 8'd1;
                            state_reg            <= SCRAMBLE;
                        end else begin
                            busy       <= 1'b0;
                            move_ready <= 1'b1;
                            state_reg  <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (move_valid) begin
                            ram_write            <= 1'b1;
                            ram_write_pos        <= move_pos;
                            ram_write_horizontal <= move_horizontal;
                            ram_write_increase   <= move_increase;
                            move_ready           <= 1'b0;
                            busy                 <= 1'b1;
                            state_reg            <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (move_count != 16'hFFFF) begin
                            move_count <= move_count + 16'd1;
                        end
                        wait_cnt_reg <= 8'd0;
                        state_reg    <= SETTLE;
                    end
                    SETTLE: begin
                        if (!settle_done) begin
                            wait_cnt_reg <= wait_cnt_reg + 8'd1;
                        end else if (ram_offset_all_zero) begin
                            busy      <= 1'b0;
                            solved    <= 1'b1;
                            state_reg <= SOLVED;
                        end else begin
                            busy       <= 1'b0;
                            move_ready <= 1'b1;
                            state_reg  <= PLAY;
                        end
                    end
                    SOLVED: begin
                        state_reg <= SOLVED;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f3_move_ctrl.sv
// Directed bench for f3_move_ctrl; each DUT drives a small behavioural model of the f3_ram offset store.
module tb_f3_move_ctrl;

    logic sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    logic        reset_n;
    logic        start;
    logic        mv_valid1;
    logic [3:0]  mv_pos1;
    logic        mv_h1;
    logic        mv_inc1;
    logic        move_ready1;
    logic [3:0]  wr_pos1;
    logic        wr_h1;
    logic        wr_inc1;
    logic        ram_write1;
    logic        ram_reset1;
    logic [15:0] move_count1;
    logic        busy1;
    logic        solved1;
    logic        az1;

    logic        mv_valid2 = 1'b0;
    logic [3:0]  mv_pos2   = 4'd0;
    logic        mv_h2     = 1'b0;
    logic        mv_inc2   = 1'b0;
    logic        move_ready2;
    logic [3:0]  wr_pos2;
    logic        wr_h2;
    logic        wr_inc2;
    logic        ram_write2;
    logic        ram_reset2;
    logic [15:0] move_count2;
    logic        busy2;
    logic        solved2;
    logic        az2;

    f3_move_ctrl dut1 (
        .sysclk(sysclk), .reset_n(reset_n), .start(start),
        .move_valid(mv_valid1), .move_pos(mv_pos1), .move_horizontal(mv_h1), .move_increase(mv_inc1),
        .move_ready(move_ready1), .ram_write_pos(wr_pos1), .ram_write_horizontal(wr_h1),
        .ram_write_increase(wr_inc1), .ram_write(ram_write1), .ram_reset(ram_reset1),
        .ram_offset_all_zero(az1), .move_count(move_count1), .busy(busy1), .solved(solved1)
    );

    // two-move batches from this seed cancel out, forcing a second batch
    f3_move_ctrl #(.SCRAMBLE_MOVES(2), .SEED(16'h003F), .SETTLE_CYCLES(2)) dut2 (
        .sysclk(sysclk), .reset_n(reset_n), .start(start),
        .move_valid(mv_valid2), .move_pos(mv_pos2), .move_horizontal(mv_h2), .move_increase(mv_inc2),
        .move_ready(move_ready2), .ram_write_pos(wr_pos2), .ram_write_horizontal(wr_h2),
        .ram_write_increase(wr_inc2), .ram_write(ram_write2), .ram_reset(ram_reset2),
        .ram_offset_all_zero(az2), .move_count(move_count2), .busy(busy2), .solved(solved2)
    );

    // offset store models: 16 x and 16 y offsets, wrap mod 16, registered all-zero flag
    logic [3:0] off1 [0:31];
    logic [3:0] off2 [0:31];
    logic       z1;
    logic       z2;

    always @(posedge sysclk) begin
        if (ram_reset1) begin
            for (int i = 0; i < 32; i++) off1[i] <= 4'd0;
        end else if (ram_write1) begin
            off1[{wr_h1, wr_pos1}] <= off1[{wr_h1, wr_pos1}] + (wr_inc1 ? 4'd1 : 4'hF);
        end
        if (ram_reset2) begin
            for (int i = 0; i < 32; i++) off2[i] <= 4'd0;
        end else if (ram_write2) begin
            off2[{wr_h2, wr_pos2}] <= off2[{wr_h2, wr_pos2}] + (wr_inc2 ? 4'd1 : 4'hF);
        end
        az1 <= z1;
        az2 <= z2;
    end

    always_comb begin
        z1 = 1'b1;
        z2 = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (off1[i] != 4'd0) z1 = 1'b0;
            if (off2[i] != 4'd0) z2 = 1'b0;
        end
    end

    // write monitor: records {increase, horizontal, pos} and cycle of every strobe
    logic [5:0] wq [$];
    int         wc [$];
    logic [5:0] w2q [$];
    int         cyc     = 0;
    int         last_wr = -100;
    int         viol    = 0;

    always @(negedge sysclk) begin
        cyc++;
        if (ram_write1) begin
            wq.push_back({wr_inc1, wr_h1, wr_pos1});
            wc.push_back(cyc);
            if (cyc - last_wr < 3) viol++;
            last_wr = cyc;
        end
        if (ram_write1 && ram_reset1) viol++;
        if (ram_write2) w2q.push_back({wr_inc2, wr_h2, wr_pos2});
    end

    logic [10:0] ctl1;
    assign ctl1 = {ram_write1, ram_reset1, move_ready1, busy1, solved1, wr_pos1, wr_h1, wr_inc1};

    int checks   = 0;
    int failures = 0;
    logic [5:0] exp_wr [0:31];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic wait_play(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (move_ready1) break;
            tick();
        end
    endtask

    function automatic logic [5:0] wr_at(input int idx);
        if (idx < wq.size()) return wq[idx];
        return 6'd0;
    endfunction

    task automatic start_game(input string tag);
        int base;
        int n;
        int bad;
        int gaps;
        base = wq.size();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_eq({tag, "_reset_pulse"}, 32'(ram_reset1), 32'd1);
        chk_eq({tag, "_clear_no_write"}, 32'(ram_write1), 32'd0);
        chk_eq({tag, "_clear_count"}, 32'(move_count1), 32'd0);
        tick();
        chk_eq({tag, "_reset_once"}, 32'(ram_reset1), 32'd0);
        wait_play(300);
        chk_eq({tag, "_ready"}, 32'(move_ready1), 32'd1);
        chk_eq({tag, "_not_busy"}, 32'(busy1), 32'd0);
        n = wq.size() - base;
        chk_eq({tag, "_nwrites"}, 32'(n), 32'd32);
        bad  = 0;
        gaps = 0;
        for (int k = 0; k < n && k < 32; k++) begin
            if (wq[base + k] != exp_wr[k]) bad++;
            if (k > 0 && wc[base + k] - wc[base + k - 1] != 3) gaps++;
        end
        chk_eq({tag, "_fields"}, 32'(bad), 32'd0);
        chk_eq({tag, "_gaps"}, 32'(gaps), 32'd0);
        chk_eq({tag, "_first_write"}, 32'(wr_at(base)), 32'h21);
        chk_eq({tag, "_second_write"}, 32'(wr_at(base + 1)), 32'h30);
    endtask

    task automatic play_move(input logic [3:0] pos, input logic h, input logic inc);
        mv_pos1   = pos;
        mv_h1     = h;
        mv_inc1   = inc;
        mv_valid1 = 1'b1;
        tick();
        mv_valid1 = 1'b0;
    endtask

    initial begin
        logic [15:0] l;
        int base;
        int base2;
        int sent;

        l = 16'hACE1;
        for (int k = 0; k < 32; k++) begin
            exp_wr[k] = {l[5], l[4], l[3:0]};
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end

        reset_n   = 1'b0;
        start     = 1'b0;
        mv_valid1 = 1'b0;
        mv_pos1   = 4'd0;
        mv_h1     = 1'b0;
        mv_inc1   = 1'b0;

        // 1: reset, then idle with no start
        repeat (3) tick();
        chk_eq("rst_ctl", 32'(ctl1), 32'd0);
        chk_eq("rst_count", 32'(move_count1), 32'd0);
        reset_n = 1'b1;
        repeat (10) tick();
        chk_eq("idle_ctl", 32'(ctl1), 32'd0);
        chk_eq("idle_count", 32'(move_count1), 32'd0);

        // 2 and 3: default scramble on dut1, cancelling batch on dut2
        base2 = w2q.size();
        start_game("s2");
        chk_eq("s3_nwrites", 32'(w2q.size() - base2), 32'd4);
        chk_eq("s3_w0", 32'((w2q.size() > base2 + 0) ? w2q[base2 + 0] : 6'd0), 32'h3F);
        chk_eq("s3_w1", 32'((w2q.size() > base2 + 1) ? w2q[base2 + 1] : 6'd0), 32'h1F);
        chk_eq("s3_w2", 32'((w2q.size() > base2 + 2) ? w2q[base2 + 2] : 6'd0), 32'h0F);
        chk_eq("s3_w3", 32'((w2q.size() > base2 + 3) ? w2q[base2 + 3] : 6'd0), 32'h07);
        chk_eq("s3_ready", 32'(move_ready2), 32'd1);

        // 4: undo the scramble, newest write first
        sent = 0;
        for (int k = 31; k >= 0; k--) begin
            play_move(exp_wr[k][3:0], exp_wr[k][4], ~exp_wr[k][5]);
            sent++;
            chk_eq("s4_issue", 32'(ram_write1), 32'd1);
            chk_eq("s4_fields", 32'({wr_inc1, wr_h1, wr_pos1}), 32'({~exp_wr[k][5], exp_wr[k][4], exp_wr[k][3:0]}));
            chk_eq("s4_ready_drop", 32'(move_ready1), 32'd0);
            for (int i = 0; i < 20 && !(move_ready1 || solved1); i++) tick();
            chk_eq("s4_solved", 32'(solved1), 32'(z1));
            chk_eq("s4_count", 32'(move_count1), 32'(sent));
            if (solved1) break;
        end
        chk_eq("s4_final_solved", 32'(solved1), 32'd1);
        chk_eq("s4_final_count", 32'(move_count1), 32'd32);
        chk_eq("s4_solved_not_ready", 32'(move_ready1), 32'd0);
        base = wq.size();
        mv_valid1 = 1'b1;
        repeat (3) tick();
        mv_valid1 = 1'b0;
        chk_eq("ignored_move_writes", 32'(wq.size() - base), 32'd0);
        chk_eq("ignored_move_count", 32'(move_count1), 32'd32);
        chk_eq("ignored_move_solved", 32'(solved1), 32'd1);

        // 5: start collides with a handshake
        start_game("s5");
        play_move(4'd3, 1'b0, 1'b1);
        for (int i = 0; i < 20 && !move_ready1; i++) tick();
        chk_eq("s5_count_one", 32'(move_count1), 32'd1);
        mv_pos1   = 4'd9;
        mv_valid1 = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        mv_valid1 = 1'b0;
        chk_eq("s5_reset_pulse", 32'(ram_reset1), 32'd1);
        chk_eq("s5_no_move_write", 32'(ram_write1), 32'd0);
        chk_eq("s5_count_cleared", 32'(move_count1), 32'd0);
        chk_eq("s5_not_ready", 32'(move_ready1), 32'd0);
        tick();
        chk_eq("s5_scramble_write", 32'({ram_write1, wr_inc1, wr_h1, wr_pos1}), 32'h61);
        wait_play(300);
        chk_eq("s5_ready_again", 32'(move_ready1), 32'd1);

        // 6: asynchronous reset during SETTLE, then an identical replay
        play_move(4'd5, 1'b1, 1'b0);
        tick();
        chk_eq("s6_settle_busy", 32'(busy1), 32'd1);
        chk_eq("s6_settle_count", 32'(move_count1), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_eq("s6_async_ctl", 32'(ctl1), 32'd0);
        chk_eq("s6_async_count", 32'(move_count1), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk_eq("s6_idle_ctl", 32'(ctl1), 32'd0);
        start_game("s6");

        chk_eq("write_spacing", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/f3_move_ctrl.md
Name: f3_move_ctrl

Overview:
- Command-side master for f3_ram: the only block that drives the offset store's write and reset strobes.
- On a start request it clears the store, then scrambles it with a pseudo-random move sequence.
- It then accepts player moves through a valid/ready handshake and tracks the move count.
- It reads back ram_offset_all_zero after every settled write and declares the puzzle solved.

Parameters:
SCRAMBLE_MOVES, 32, number of random writes per scramble batch (1..255)
SEED, 16'hACE1, LFSR value loaded at reset and on every start (must be nonzero)
SETTLE_CYCLES, 2, idle cycles after each ram_write before ram_offset_all_zero is sampled (>=2)

Ports:
sysclk  in  1  system clock; all state changes on its rising edge
reset_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: clear and scramble a new game; honoured in any state
move_valid  in  1  player move request present
move_pos  in  4  row/column index of the move
move_horizontal  in  1  1 = horizontal move (y offsets), 0 = vertical move (x offsets)
move_increase  in  1  1 = +1, 0 = -1
move_ready  out  1  high only in PLAY; transfer on rising edge with move_valid & move_ready
ram_write_pos  out  4  to f3_ram
ram_write_horizontal  out  1  to f3_ram
ram_write_increase  out  1  to f3_ram
ram_write  out  1  one-cycle write strobe to f3_ram
ram_reset  out  1  one-cycle clear strobe to f3_ram
ram_offset_all_zero  in  1  from f3_ram; valid SETTLE_CYCLES after a write
move_count  out  16  player moves since last start; saturates at 16'hFFFF
busy  out  1  high in CLEAR, SCRAMBLE, SCR_SETTLE, ISSUE, SETTLE
solved  out  1  high in SOLVED

Behaviour:
- All outputs are registered.
- Reset (asynchronous, reset_n=0):
  - state IDLE, lfsr=SEED, all counters 0.
  - All outputs 0: ram_write, ram_reset, move_ready, busy, solved, move_count, write fields.
  - Reset mid-write drops ram_write immediately; no partial sequence resumes.
- States:
  - IDLE: outputs idle; start -> CLEAR.
  - CLEAR: ram_reset=1 for exactly one cycle; scramble counter=0; move_count=0; lfsr=SEED -> SCRAMBLE.
  - SCRAMBLE: ram_write=1 for one cycle with pos=lfsr[3:0], horizontal=lfsr[4], increase=lfsr[5].
    - lfsr then advances once as a Galois right shift: next = (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
    - Counter increments -> SCR_SETTLE.
  - SCR_SETTLE: wait SETTLE_CYCLES cycles.
    - If counter < SCRAMBLE_MOVES -> SCRAMBLE.
    - Else, if ram_offset_all_zero=1 (scramble cancelled out): counter=0 -> SCRAMBLE (new batch, LFSR continues).
    - Else -> PLAY.
  - PLAY: move_ready=1. On handshake, latch move fields; move_ready drops the next cycle -> ISSUE.
  - ISSUE: ram_write=1 for one cycle with the latched fields; move_count+1 (saturating) -> SETTLE.
  - SETTLE: wait SETTLE_CYCLES cycles, then sample ram_offset_all_zero: 1 -> SOLVED, 0 -> PLAY.
  - SOLVED: solved=1, move_ready=0; holds until start or reset.
- Write spacing:
  - ram_write is never high on two consecutive cycles.
  - Minimum spacing between strobes is SETTLE_CYCLES+1 cycles.
  - ram_write and ram_reset are never high together.
- Write fields hold their last value when ram_write=0.
- Offsets wrap mod 16 inside f3_ram; this block performs no range checks.
- start has priority over every state transition, including the same cycle as a move handshake. That move is discarded and not counted; CLEAR follows.
- move_valid outside PLAY is ignored; no request is buffered.
- Player moves that reverse a scramble move are legal. Solve detection relies only on ram_offset_all_zero.

Test Plan:
1. reset_n=0 then 1, no start -> all outputs 0, move_ready=0, state IDLE indefinitely.
2. start pulse, SEED=16'hACE1 (stores modelled by an f3_ram instance):
   - Next cycle: ram_reset=1 for exactly one cycle.
   - First write: pos=1, horizontal=0, increase=1.
   - Second write: pos=0, horizontal=1, increase=1.
   - Writes are 3 cycles apart.
   - Exactly 32 writes, then busy=0 and move_ready=1.
3. SCRAMBLE_MOVES=2 with a seed whose two moves cancel:
   - The all-zero check fails, so a second batch runs.
   - 4 writes total before PLAY.
4. In PLAY, replay the inverse of every scramble write through the handshake:
   - Each accepted move gives one ram_write 1 cycle after the handshake.
   - move_count increments; solved=1 after the last move's settle.
   - move_count = number of moves sent.
5. Assert start in the same cycle as move_valid & move_ready -> no ram_write for that move, move_count=0, ram_reset pulse next cycle.
6. Drop reset_n during SETTLE, then release:
   - ram_write=0 and solved=0 immediately.
   - move_count=0, IDLE.
   - A following start reproduces the scenario-2 sequence exactly.
